rhythm_cascade: RTL and testbench

Parametrised multi-level rhythm divider that extends the single-stage theta→delta counter into a cascade of LEVELS tick-counting stages, e.g. theta→delta→topic-block. Each stage has a runtime-programmable terminal count with boundary-safe shadow loading. A global resync forces a topic switch, and a top-level boundary index is maintained. The block sits downstream of theta_oscillator and feeds episode/topic bookkeeping logic.

---
 rtl/rhythm_pkg.sv | 12 +
 rtl/rhythm_stage.sv | 57 +++++
 rtl/rhythm_cascade.sv | 63 ++++++
 tb/tb_rhythm_cascade.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// Shared constants and slice helper for the rhythm_cascade divider.
package rhythm_pkg;

    localparam int RHYTHM_CNT_W = 3;
    localparam int RHYTHM_TC    = 4;

    // Bit offset of stage k inside a flattened LEVELS*w vector.
    function automatic int slice_offset(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/rhythm_stage.sv
// One tick-counting stage: position counter, active/shadow terminal count,
// registered boundary pulse and a last-position flag.
module rhythm_stage
    import rhythm_pkg::*;
#(
    parameter int CNT_W      = RHYTHM_CNT_W,
    parameter int DEFAULT_TC = RHYTHM_TC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             resync,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_tc,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] tc_active,
    output logic             tick,
    output logic             last
);

    logic [CNT_W-1:0] tc_shadow;
    logic [CNT_W-1:0] tc_next;

    // A write landing on a wrap/resync cycle goes straight into force.
    assign tc_next = cfg_we ? cfg_tc : tc_shadow;

    // NOTE: state registers use non-blocking assignments so every stage
    // samples its neighbour's pre-edge value, keeping the cascade ordered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            tick      <= 1'b0;
            tc_active <= CNT_W'(DEFAULT_TC);
            tc_shadow <= CNT_W'(DEFAULT_TC);
        end else begin
            tick <= 1'b0;
            if (cfg_we)
                tc_shadow <= cfg_tc;
            if (resync) begin
                cnt       <= '0;
                tc_active <= tc_next;
            end else if (pulse_in) begin
                // >= rather than == lets a counter stranded above a lowered TC recover.
                if (cnt >= tc_active) begin
                    cnt       <= '0;
                    tick      <= 1'b1;
                    tc_active <= tc_next;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign last = (cnt == tc_active);

endmodule

// File: rtl/rhythm_cascade.sv
// Cascade of rhythm_stage dividers (e.g. theta->delta->topic) with stage-0
// gating, resync broadcast and a top-level boundary index.
module rhythm_cascade
    import rhythm_pkg::*;
#(
    parameter int LEVELS     = 2,
    parameter int CNT_W      = RHYTHM_CNT_W,
    parameter int DEFAULT_TC = RHYTHM_TC,
    parameter int IDX_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_tick,
    input  logic                    resync,
    input  logic                    cfg_we,
    input  logic [LEVELS*CNT_W-1:0] cfg_tc,
    output logic [LEVELS*CNT_W-1:0] tc_active,
    output logic [LEVELS*CNT_W-1:0] cnt_o,
    output logic [LEVELS-1:0]       tick_o,
    output logic [LEVELS-1:0]       last_o,
    output logic [IDX_W-1:0]        top_idx
);

    logic [LEVELS-1:0] stage_in;

    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        localparam int OFS = slice_offset(k, CNT_W);

        // Stage 0 sees the gated input; deeper stages see the registered tick
        // above them, so ticks already in flight drain even with en low.
        if (k == 0) begin : g_head
            assign stage_in[k] = in_tick & en;
        end else begin : g_link
            assign stage_in[k] = tick_o[k-1];
        end

        rhythm_stage #(
            .CNT_W      (CNT_W),
            .DEFAULT_TC (DEFAULT_TC)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .pulse_in  (stage_in[k]),
            .resync    (resync),
            .cfg_we    (cfg_we),
            .cfg_tc    (cfg_tc[OFS +: CNT_W]),
            .cnt       (cnt_o[OFS +: CNT_W]),
            .tc_active (tc_active[OFS +: CNT_W]),
            .tick      (tick_o[k]),
            .last      (last_o[k])
        );
    end

    // The index survives resync; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            top_idx <= '0;
        else if (tick_o[LEVELS-1])
            top_idx <= top_idx + IDX_W'(1);
    end

endmodule

// File: tb/tb_rhythm_cascade.sv
// Directed self-checking bench for rhythm_cascade (LEVELS=2, CNT_W=3, TC=4).
module tb_rhythm_cascade;

    logic       clk;
    logic       rst;
    logic       en;
    logic       in_tick;
    logic       resync;
    logic       cfg_we;
    logic [5:0] cfg_tc;
    logic [5:0] tc_active;
    logic [5:0] cnt_o;
    logic [1:0] tick_o;
    logic [1:0] last_o;
    logic [7:0] top_idx;

    int n_checks;
    int n_fail;

    rhythm_cascade #(
        .LEVELS     (2),
        .CNT_W      (3),
        .DEFAULT_TC (4),
        .IDX_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_tick   (in_tick),
        .resync    (resync),
        .cfg_we    (cfg_we),
        .cfg_tc    (cfg_tc),
        .tc_active (tc_active),
        .cnt_o     (cnt_o),
        .tick_o    (tick_o),
        .last_o    (last_o),
        .top_idx   (top_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_tick();
        in_tick = 1'b1;
        @(posedge clk);
        #1;
        in_tick = 1'b0;
    endtask

    task automatic resync_load(input logic [5:0] tc);
        resync = 1'b1;
        cfg_we = 1'b1;
        cfg_tc = tc;
        @(posedge clk);
        #1;
        resync = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        n_checks++;
        if (cnt_o !== 6'd0 || tick_o !== 2'b00 || top_idx !== 8'd0) begin
            $display("FAIL reset_outputs: cnt=%h tick=%b idx=%0d, want 0/00/0", cnt_o, tick_o, top_idx);
            n_fail++;
        end
        n_checks++;
        if (tc_active !== {3'd4, 3'd4}) begin
            $display("FAIL reset_tc: got %o want 44", tc_active);
            n_fail++;
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_default_divide();
        for (int i = 1; i <= 25; i++) begin
            send_tick();
            n_checks++;
            if (tick_o[0] !== ((i % 5) == 0) || cnt_o[2:0] !== 3'(i % 5)) begin
                $display("FAIL div_stage0 tick %0d: tick0=%b cnt0=%0d want %b/%0d",
                         i, tick_o[0], cnt_o[2:0], ((i % 5) == 0), i % 5);
                n_fail++;
            end
            idle(1);
            n_checks++;
            if (tick_o !== {(i == 25), 1'b0}) begin
                $display("FAIL div_stage1 tick %0d: tick=%b want %b", i, tick_o, {(i == 25), 1'b0});
                n_fail++;
            end
            idle(1);
            n_checks++;
            if (top_idx !== ((i == 25) ? 8'd1 : 8'd0)) begin
                $display("FAIL div_top_idx tick %0d: got %0d want %0d", i, top_idx, (i == 25));
                n_fail++;
            end
        end
    endtask

    task automatic test_shadow_load();
        for (int i = 1; i <= 2; i++) begin
            send_tick();
            idle(2);
        end
        cfg_we = 1'b1;
        cfg_tc = {3'd4, 3'd1};
        idle(1);
        cfg_we = 1'b0;
        n_checks++;
        if (tc_active !== {3'd4, 3'd4} || cnt_o[2:0] !== 3'd2) begin
            $display("FAIL shadow_no_midperiod: tc=%o cnt0=%0d want 44/2", tc_active, cnt_o[2:0]);
            n_fail++;
        end
        for (int i = 3; i <= 5; i++) begin
            send_tick();
            n_checks++;
            if (tick_o[0] !== (i == 5) || tc_active[2:0] !== ((i == 5) ? 3'd1 : 3'd4)) begin
                $display("FAIL shadow_old_period tick %0d: tick0=%b tc0=%0d want %b/%0d",
                         i, tick_o[0], tc_active[2:0], (i == 5), (i == 5) ? 1 : 4);
                n_fail++;
            end
            idle(2);
        end
        for (int j = 1; j <= 4; j++) begin
            send_tick();
            n_checks++;
            if (tick_o[0] !== ((j % 2) == 0)) begin
                $display("FAIL shadow_new_period tick %0d: tick0=%b want %b", j, tick_o[0], ((j % 2) == 0));
                n_fail++;
            end
            idle(2);
        end
        n_checks++;
        if (cnt_o[5:3] !== 3'd3 || top_idx !== 8'd1) begin
            $display("FAIL shadow_stage1: cnt1=%0d idx=%0d want 3/1", cnt_o[5:3], top_idx);
            n_fail++;
        end
    endtask

    task automatic test_resync();
        resync_load({3'd4, 3'd4});
        n_checks++;
        if (cnt_o !== 6'd0 || tc_active !== {3'd4, 3'd4}) begin
            $display("FAIL resync_load: cnt=%o tc=%o want 00/44", cnt_o, tc_active);
            n_fail++;
        end
        for (int i = 1; i <= 13; i++) begin
            send_tick();
            idle(2);
        end
        n_checks++;
        if (cnt_o !== {3'd2, 3'd3}) begin
            $display("FAIL resync_setup: cnt=%o want 23", cnt_o);
            n_fail++;
        end
        in_tick = 1'b1;
        resync  = 1'b1;
        idle(1);
        in_tick = 1'b0;
        resync  = 1'b0;
        n_checks++;
        if (cnt_o !== 6'd0 || tick_o !== 2'b00 || top_idx !== 8'd1) begin
            $display("FAIL resync_clear: cnt=%o tick=%b idx=%0d want 00/00/1", cnt_o, tick_o, top_idx);
            n_fail++;
        end
        for (int i = 1; i <= 5; i++) begin
            send_tick();
            n_checks++;
            if (tick_o[0] !== (i == 5) || cnt_o[2:0] !== 3'(i % 5)) begin
                $display("FAIL resync_restart tick %0d: tick0=%b cnt0=%0d want %b/%0d",
                         i, tick_o[0], cnt_o[2:0], (i == 5), i % 5);
                n_fail++;
            end
            idle(2);
        end
    endtask

    task automatic test_back_to_back();
        resync_load({3'd4, 3'd0});
        n_checks++;
        if (tc_active !== {3'd4, 3'd0} || cnt_o !== 6'd0) begin
            $display("FAIL b2b_setup: tc=%o cnt=%o want 40/00", tc_active, cnt_o);
            n_fail++;
        end
        in_tick = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            n_checks++;
            if (tick_o[0] !== 1'b1 || last_o[0] !== 1'b1) begin
                $display("FAIL b2b_tick cycle %0d: tick0=%b last0=%b want 1/1", i, tick_o[0], last_o[0]);
                n_fail++;
            end
        end
        in_tick = 1'b0;
        idle(1);
        n_checks++;
        if (tick_o !== 2'b00 || cnt_o[5:3] !== 3'd4 || last_o[1] !== 1'b1) begin
            $display("FAIL b2b_stage1: tick=%b cnt1=%0d last1=%b want 00/4/1", tick_o, cnt_o[5:3], last_o[1]);
            n_fail++;
        end
    endtask

    task automatic test_enable();
        resync_load({3'd4, 3'd4});
        for (int i = 1; i <= 4; i++) begin
            send_tick();
            idle(2);
        end
        send_tick();
        n_checks++;
        if (tick_o[0] !== 1'b1) begin
            $display("FAIL en_wrap: tick0=%b want 1", tick_o[0]);
            n_fail++;
        end
        en = 1'b0;
        send_tick();
        n_checks++;
        if (cnt_o !== {3'd1, 3'd0} || tick_o[0] !== 1'b0) begin
            $display("FAIL en_drain: cnt=%o tick0=%b want 10/0", cnt_o, tick_o[0]);
            n_fail++;
        end
        idle(2);
        en = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            send_tick();
            idle(2);
        end
        en = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            send_tick();
            idle(2);
        end
        n_checks++;
        if (cnt_o !== {3'd1, 3'd2} || tick_o !== 2'b00) begin
            $display("FAIL en_frozen: cnt=%o tick=%b want 12/00", cnt_o, tick_o);
            n_fail++;
        end
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        cfg_we = 1'b1;
        cfg_tc = {3'd2, 3'd2};
        idle(1);
        cfg_we = 1'b0;
        send_tick();
        idle(2);
        send_tick();
        idle(2);
        send_tick();
        n_checks++;
        if (tick_o[0] !== 1'b1 || tc_active !== {3'd4, 3'd2}) begin
            $display("FAIL rst_setup: tick0=%b tc=%o want 1/42", tick_o[0], tc_active);
            n_fail++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (cnt_o !== 6'd0 || tick_o !== 2'b00 || top_idx !== 8'd0 || tc_active !== {3'd4, 3'd4}) begin
            $display("FAIL rst_async: cnt=%o tick=%b idx=%0d tc=%o want 00/00/0/44",
                     cnt_o, tick_o, top_idx, tc_active);
            n_fail++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        resync = 1'b1;
        idle(1);
        resync = 1'b0;
        n_checks++;
        if (tc_active !== {3'd4, 3'd4}) begin
            $display("FAIL rst_shadow: tc=%o want 44", tc_active);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        en       = 1'b1;
        in_tick  = 1'b0;
        resync   = 1'b0;
        cfg_we   = 1'b0;
        cfg_tc   = '0;
        test_reset();
        test_default_divide();
        test_shadow_load();
        test_resync();
        test_back_to_back();
        test_enable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
